acc_engine: RTL and testbench

ACC_ENGINE -- requirements
Module: acc_engine

---
 rtl/acc_pkg.sv | 40 ++++
 rtl/acc_reduce.sv | 30 +++
 rtl/acc_engine.sv | 123 ++++++++++++
 tb/tb_acc_engine.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
//------------------------------------------------------------------------------
// Module : acc_pkg
// Brief  : Shared FSM states, funct codes and identity values for acc_engine.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } accState_t;

  localparam logic [5:0]  c_FUNCT_SUM = 6'h20;
  localparam logic [5:0]  c_FUNCT_XOR = 6'h26;
  localparam logic [5:0]  c_FUNCT_MAX = 6'h2A;

  localparam logic [31:0] c_ID_SUM = 32'h0000_0000;
  localparam logic [31:0] c_ID_XOR = 32'h0000_0000;
  localparam logic [31:0] c_ID_MAX = 32'h8000_0000;

  function automatic logic isSupported(input logic [5:0] funct);
    return (funct == c_FUNCT_SUM) || (funct == c_FUNCT_XOR) || (funct == c_FUNCT_MAX);
  endfunction

  function automatic logic [31:0] identityOf(input logic [5:0] funct);
    case (funct)
      c_FUNCT_MAX: return c_ID_MAX;
      c_FUNCT_XOR: return c_ID_XOR;
      default:     return c_ID_SUM;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/acc_reduce.sv
//------------------------------------------------------------------------------
// Module : acc_reduce
// Brief  : Combinational fold of one memory word into the running accumulator.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module acc_reduce
  import acc_pkg::*;
(
  input  logic [31:0] i_acc,
  input  logic [31:0] i_word,
  input  logic [5:0]  i_funct,
  output logic [31:0] o_acc
);

  always_comb begin
    o_acc = i_acc;
    case (i_funct)
      c_FUNCT_SUM: o_acc = i_acc + i_word;
      c_FUNCT_XOR: o_acc = i_acc ^ i_word;
      c_FUNCT_MAX: o_acc = ($signed(i_word) > $signed(i_acc)) ? i_word : i_acc;
      default:     o_acc = i_acc;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/acc_engine.sv
//------------------------------------------------------------------------------
// Module : acc_engine
// Brief  : Reads N words from memory, reduces them, writes the result after them.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module acc_engine
  import acc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        accbypass,
  input  logic [31:0] fullinstruction,
  input  logic [31:0] startaddr,
  input  logic [31:0] datasize,
  output logic        accdone,
  output logic        busy,
  output logic        memreq,
  output logic        memwe,
  output logic [31:0] memaddr,
  output logic [31:0] memwdata,
  input  logic [31:0] memrdata,
  input  logic        memack
);

  accState_t   r_state;
  accState_t   w_nextState;
  logic [5:0]  r_funct;
  logic [31:0] r_ptr;
  logic [31:0] r_count;
  logic [31:0] r_acc;
  logic [31:0] w_foldAcc;
  logic        w_start;
  logic        w_readAck;
  logic        w_unusedBits;

  assign w_unusedBits = &{1'b0, fullinstruction[31:6], startaddr[1:0]};
  assign w_start      = (r_state == ST_IDLE) && accbypass;
  assign w_readAck    = (r_state == ST_READ) && memack;

  acc_reduce u_reduce (
    .i_acc   (r_acc),
    .i_word  (memrdata),
    .i_funct (r_funct),
    .o_acc   (w_foldAcc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (accbypass) begin
          // Nothing to read or nothing we know how to fold: complete without touching memory.
          if ((datasize == 32'd0) || !isSupported(fullinstruction[5:0])) begin
            w_nextState = ST_DONE;
          end else begin
            w_nextState = ST_READ;
          end
        end
      end
      ST_READ:  if (memack && (r_count == 32'd1)) w_nextState = ST_WRITE;
      ST_WRITE: if (memack) w_nextState = ST_DONE;
      ST_DONE:  w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  // After the last read the pointer already sits at start + 4*N, the result slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_funct <= 6'd0;
      r_ptr   <= 32'd0;
      r_count <= 32'd0;
      r_acc   <= 32'd0;
    end else if (w_start) begin
      r_funct <= fullinstruction[5:0];
      r_ptr   <= {startaddr[31:2], 2'b00};
      r_count <= datasize;
      r_acc   <= identityOf(fullinstruction[5:0]);
    end else if (w_readAck) begin
      r_acc   <= w_foldAcc;
      r_ptr   <= r_ptr + 32'd4;
      r_count <= r_count - 32'd1;
    end
  end

  always_comb begin
    accdone  = 1'b0;
    busy     = 1'b1;
    memreq   = 1'b0;
    memwe    = 1'b0;
    memaddr  = 32'd0;
    memwdata = 32'd0;
    case (r_state)
      ST_IDLE:  busy = 1'b0;
      ST_READ: begin
        memreq  = 1'b1;
        memaddr = r_ptr;
      end
      ST_WRITE: begin
        memreq   = 1'b1;
        memwe    = 1'b1;
        memaddr  = r_ptr;
        memwdata = r_acc;
      end
      ST_DONE:  accdone = 1'b1;
      default:  busy = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_acc_engine.sv
//------------------------------------------------------------------------------
// Module : tb_acc_engine
// Brief  : Scoreboard bench for acc_engine with a simple stalling memory model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_acc_engine;

  localparam int K_RD   = 0;
  localparam int K_WR   = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } sbEntry_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        accbypass = 1'b0;
  logic [31:0] fullinstruction = 32'd0;
  logic [31:0] startaddr = 32'd0;
  logic [31:0] datasize = 32'd0;
  logic        accdone;
  logic        busy;
  logic        memreq;
  logic        memwe;
  logic [31:0] memaddr;
  logic [31:0] memwdata;
  logic [31:0] memrdata = 32'd0;
  logic        memack = 1'b0;

  sbEntry_t    sb[$];
  logic [31:0] words[$];
  logic [31:0] mem [logic [31:0]];
  int          nVec = 0;
  int          nMis = 0;
  int          doneCount = 0;
  bit          stallMode = 1'b0;
  logic        prevReq = 1'b0;
  logic        prevAck = 1'b0;
  logic        prevWe = 1'b0;
  logic [31:0] prevAddr = 32'd0;

  acc_engine dut (
    .clk             (clk),
    .reset           (reset),
    .accbypass       (accbypass),
    .fullinstruction (fullinstruction),
    .startaddr       (startaddr),
    .datasize        (datasize),
    .accdone         (accdone),
    .busy            (busy),
    .memreq          (memreq),
    .memwe           (memwe),
    .memaddr         (memaddr),
    .memwdata        (memwdata),
    .memrdata        (memrdata),
    .memack          (memack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    if (obs !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fold(input logic [5:0] f, input logic [31:0] a, input logic [31:0] w);
    if (f == 6'h20) return a + w;
    if (f == 6'h26) return a ^ w;
    return ($signed(w) > $signed(a)) ? w : a;
  endfunction

  // Memory side: ack and read data change just after the clock edge.
  always begin
    @(posedge clk);
    #1;
    memack   = stallMode ? 1'($urandom_range(0, 1)) : 1'b1;
    memrdata = mem.exists(memaddr) ? mem[memaddr] : (32'hBAD0_0000 ^ memaddr);
  end

  always @(negedge clk) begin
    sbEntry_t e;
    if (reset) begin
      if (memreq && memack) begin
        if (sb.size() == 0) begin
          check("unexpected_xfer", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("xfer_kind", 32'(memwe ? K_WR : K_RD), 32'(e.kind));
          check("xfer_addr", memaddr, e.addr);
          if (e.kind == K_WR) check("xfer_wdata", memwdata, e.data);
        end
      end
      if (accdone) begin
        doneCount++;
        check("done_noreq", 32'(memreq), 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("done_kind", 32'(K_DONE), 32'(e.kind));
        end
      end
      if (prevReq && !prevAck) begin
        check("stall_req", 32'(memreq), 32'd1);
        check("stall_addr", memaddr, prevAddr);
        check("stall_we", 32'(memwe), 32'(prevWe));
      end
    end
    prevReq  = memreq;
    prevAck  = memack;
    prevWe   = memwe;
    prevAddr = memaddr;
  end

  task automatic runOp(input string name, input logic [5:0] f, input logic [31:0] start,
                       input logic [31:0] n, input bit chkLat, input bit poke);
    logic [31:0] base;
    logic [31:0] acc;
    int          lat;
    int          done0;
    int          expLat;
    bit          direct;
    base   = {start[31:2], 2'b00};
    direct = (n == 0) || !((f == 6'h20) || (f == 6'h26) || (f == 6'h2A));
    acc    = (f == 6'h2A) ? 32'h8000_0000 : 32'd0;
    expLat = direct ? 1 : int'(n) + 2;
    for (int i = 0; i < int'(n); i++) begin
      mem[base + 32'(4 * i)] = words[i];
      if (!direct) begin
        sb.push_back('{K_RD, base + 32'(4 * i), 32'd0});
        acc = fold(f, acc, words[i]);
      end
    end
    if (!direct) sb.push_back('{K_WR, base + 32'(4 * int'(n)), acc});
    sb.push_back('{K_DONE, 32'd0, 32'd0});
    done0 = doneCount;

    @(negedge clk);
    accbypass       = 1'b1;
    fullinstruction = {26'($urandom()), f};
    startaddr       = start;
    datasize        = n;
    @(posedge clk);
    #1;
    accbypass       = 1'b0;
    fullinstruction = $urandom();
    startaddr       = $urandom();
    datasize        = $urandom_range(0, 7);

    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) check({name, "_busy"}, 32'(busy), 32'd1);
      if (poke && lat == 2) accbypass = 1'b1;
      if (poke && lat == 3) accbypass = 1'b0;
    end while (!accdone && lat < 300);

    if (!accdone) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
    end else if (chkLat) begin
      check({name, "_latency"}, 32'(lat), 32'(expLat));
    end
    if (poke) accbypass = 1'b1;
    @(negedge clk);
    accbypass = 1'b0;
    check({name, "_done_pulse"}, 32'(accdone), 32'd0);
    check({name, "_idle"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({name, "_stay_idle"}, 32'(busy), 32'd0);
    check({name, "_done_count"}, 32'(doneCount - done0), 32'd1);
    check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int done0;
    repeat (2) @(negedge clk);
    check("rst_accdone", 32'(accdone), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_memreq", 32'(memreq), 32'd0);
    check("rst_memaddr", memaddr, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    words = '{32'd1, 32'd2, 32'd3};
    runOp("sum3", 6'h20, 32'h0000_0100, 32'd3, 1'b1, 1'b0);

    stallMode = 1'b1;
    words = '{32'hFFFF_FFF0, 32'h0000_0005};
    runOp("max_stall", 6'h2A, 32'h0000_0400, 32'd2, 1'b0, 1'b0);
    words = '{32'h1234_5678, 32'h8000_0001, 32'h0000_0010, 32'hFFFF_FFFF};
    runOp("sum_stall", 6'h20, 32'h0000_0703, 32'd4, 1'b0, 1'b0);
    stallMode = 1'b0;

    words = '{};
    runOp("sum_n0", 6'h20, 32'h0000_0100, 32'd0, 1'b1, 1'b0);
    words = '{32'd7, 32'd8, 32'd9};
    runOp("bad_funct", 6'h3F, 32'h0000_0800, 32'd3, 1'b1, 1'b0);
    words = '{32'hA5A5_0F0F, 32'h0F0F_FFFF};
    runOp("xor_wrap", 6'h26, 32'hFFFF_FFFC, 32'd2, 1'b1, 1'b0);
    words = '{32'd10, 32'd20, 32'd30};
    runOp("busy_reject", 6'h20, 32'h0000_0500, 32'd3, 1'b1, 1'b1);

    // Reset after the first of four reads.
    for (int i = 0; i < 4; i++) mem[32'h0000_0200 + 32'(4 * i)] = 32'(i + 1);
    sb.push_back('{K_RD, 32'h0000_0200, 32'd0});
    done0 = doneCount;
    @(negedge clk);
    accbypass       = 1'b1;
    fullinstruction = 32'h0000_0020;
    startaddr       = 32'h0000_0200;
    datasize        = 32'd4;
    @(posedge clk);
    #1;
    accbypass = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_accdone", 32'(accdone), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_memreq", 32'(memreq), 32'd0);
    check("mid_rst_memwe", 32'(memwe), 32'd0);
    check("mid_rst_memaddr", memaddr, 32'd0);
    check("mid_rst_memwdata", memwdata, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("in_rst_accdone", 32'(accdone), 32'd0);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_no_done", 32'(doneCount - done0), 32'd0);
    check("post_rst_sb", 32'(sb.size()), 32'd0);

    words = '{32'h0000_0042};
    runOp("after_rst", 6'h20, 32'h0000_0300, 32'd1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
